// File: rtl/stream_mux_rr_pkg.sv
// +------------------------------------------------------------------+
// | mux_pkg : shared mode type and width helper for stream_mux_rr    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_e;

    // Channel index width; never zero so a 2-channel mux still has a select bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_if.sv
// +------------------------------------------------------------------+
// | stream_mux_rr_if : N-input / 1-output valid-ready stream bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface stream_mux_rr_if
    import mux_pkg::*;
#(
    parameter  int BITS     = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2_min1(CHANNELS)
);

    mux_mode_e                     mode;
    logic [SEL_W-1:0]              select;
    logic [CHANNELS*BITS-1:0]      in_data;
    logic [CHANNELS-1:0]           in_valid;
    logic [CHANNELS-1:0]           in_last;
    logic [CHANNELS-1:0]           in_ready;
    logic [BITS-1:0]               out_data;
    logic [SEL_W-1:0]              out_chan;
    logic                          out_valid;
    logic                          out_ready;

    // The mux itself sits on the slave side of the bundle.
    modport slave (
        input  mode, select, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output mode, select, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
// +------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting after the   |
// |              previous winner.                       Rev 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] last_grant,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant
);

    int w_cand;

    // Walk from farthest to nearest so the closest requester after last_grant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        w_cand      = 0;
        for (int k = N; k >= 1; k--) begin
            w_cand = (int'(last_grant) + k) % N;
            if (req[w_cand[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = w_cand[SEL_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// +------------------------------------------------------------------+
// | stream_mux_rr : registered N:1 stream mux, manual or round-robin |
// |   MUX_PKT_LOCK_EN : hold grant on a channel until in_last beat    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int BITS     = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic            clk,
    input  logic            reset_n,
    stream_mux_rr_if.slave  bus
);

    logic             out_valid_q,  out_valid_d;
    logic [BITS-1:0]  out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_chan_q,   out_chan_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             w_load;
    logic             w_man_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_grant;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant;
    logic [BITS-1:0]  w_grant_data;

`ifdef MUX_PKT_LOCK_EN
    logic             lock_q,      lock_d;
    logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
    logic             w_grant_last;
`else
    logic             w_unused_last;
    assign w_unused_last = ^bus.in_last;
`endif

    assign w_load = !out_valid_q || bus.out_ready;

    rr_arbiter #(
        .N           (CHANNELS)
    ) u_rr_arbiter (
        .req         (bus.in_valid),
        .last_grant  (last_grant_q),
        .grant_valid (w_rr_valid),
        .grant       (w_rr_grant)
    );

    // Loop compare keeps out-of-range select values from granting anything.
    always_comb begin
        w_man_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.select == SEL_W'(i) && bus.in_valid[i]) begin
                w_man_valid = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        if (bus.mode == MODE_RR) begin
            w_grant_valid = w_rr_valid;
            w_grant       = w_rr_grant;
        end else begin
            w_grant_valid = w_man_valid;
            w_grant       = bus.select;
        end
`ifdef MUX_PKT_LOCK_EN
        if (lock_q) begin
            w_grant_valid = bus.in_valid[lock_chan_q];
            w_grant       = lock_chan_q;
        end
`endif
    end

    always_comb begin
        w_grant_data = '0;
        bus.in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_data    = bus.in_data[i*BITS +: BITS];
                bus.in_ready[i] = w_load && w_grant_valid;
            end
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_comb begin
        w_grant_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_grant_last = bus.in_last[i];
            end
        end
    end
`endif

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
`ifdef MUX_PKT_LOCK_EN
        lock_d       = lock_q;
        lock_chan_d  = lock_chan_q;
`endif
        if (w_load) begin
            if (w_grant_valid) begin
                out_valid_d  = 1'b1;
                out_data_d   = w_grant_data;
                out_chan_d   = w_grant;
                last_grant_d = w_grant;
`ifdef MUX_PKT_LOCK_EN
                lock_d       = !w_grant_last;
                lock_chan_d  = w_grant;
`endif
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    // Reset value of last_grant makes channel 0 the first round-robin winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
`ifdef MUX_PKT_LOCK_EN
            lock_q       <= 1'b0;
            lock_chan_q  <= '0;
`endif
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
`ifdef MUX_PKT_LOCK_EN
            lock_q       <= lock_d;
            lock_chan_q  <= lock_chan_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// +------------------------------------------------------------------+
// | tb_stream_mux_rr : vector table, corner sequences and randomized |
// |                    run against a reference model.    Rev 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_stream_mux_rr;
    import mux_pkg::*;

    localparam int BITS = 4;
    localparam int CH   = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.BITS(BITS), .CHANNELS(CH)) bus ();

    stream_mux_rr #(.BITS(BITS), .CHANNELS(CH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit         m_valid;
    logic [3:0] m_data;
    int         m_chan;
    int         m_last;
    bit         m_lock;
    int         m_lock_ch;

    typedef struct {
        mux_mode_e  mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_chan;
        logic [3:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.mode      = MODE_MANUAL;
        bus.select    = '0;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.in_last   = '1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        m_valid   = 0;
        m_data    = '0;
        m_chan    = 0;
        m_last    = CH - 1;
        m_lock    = 0;
        m_lock_ch = 0;
    endtask

    // Inputs are already applied just after a falling edge.
    task automatic cycle_check(input string tag, input logic [3:0] exp_ready, input logic exp_valid,
                               input logic [1:0] exp_chan, input logic [3:0] exp_data);
        #1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
        @(posedge clk);
        @(negedge clk);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({tag, " out_chan"}, 32'(bus.out_chan), 32'(exp_chan));
            check({tag, " out_data"}, 32'(bus.out_data), 32'(exp_data));
        end
    endtask

    function automatic void model_grant(output bit gv, output int g);
        gv = 0;
        g  = 0;
`ifdef MUX_PKT_LOCK_EN
        if (m_lock) begin
            g  = m_lock_ch;
            gv = bus.in_valid[g];
            return;
        end
`endif
        if (bus.mode == MODE_MANUAL) begin
            g  = int'(bus.select);
            gv = (g < CH) && bus.in_valid[g];
        end else begin
            for (int k = 1; k <= CH; k++) begin
                int c;
                c = (m_last + k) % CH;
                if (bus.in_valid[c]) begin
                    gv = 1;
                    g  = c;
                    break;
                end
            end
        end
    endfunction

    task automatic random_cycle(input int n);
        bit         gv;
        int         g;
        bit         load;
        logic [3:0] exp_rdy;
        bus.mode      = mux_mode_e'($urandom_range(0, 1));
        bus.select    = 2'($urandom_range(0, 3));
        bus.in_data   = 16'($urandom);
        bus.in_valid  = 4'($urandom);
        bus.in_last   = 4'($urandom);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        model_grant(gv, g);
        load    = !m_valid || bus.out_ready;
        exp_rdy = (load && gv) ? 4'(1 << g) : 4'b0000;
        check($sformatf("rnd%0d in_ready", n), 32'(bus.in_ready), 32'(exp_rdy));
        if (load) begin
            if (gv) begin
                m_valid   = 1;
                m_data    = bus.in_data[g*BITS +: BITS];
                m_chan    = g;
                m_last    = g;
                m_lock    = !bus.in_last[g];
                m_lock_ch = g;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rnd%0d out_valid", n), 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            check($sformatf("rnd%0d out_chan", n), 32'(bus.out_chan), 32'(m_chan));
            check($sformatf("rnd%0d out_data", n), 32'(bus.out_data), 32'(m_data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // ch0=5, ch1=7, ch2=A, ch3=C
        vecs[0]  = '{MODE_MANUAL, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hA};
        vecs[1]  = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hC};
        vecs[2]  = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h5};
        vecs[3]  = '{MODE_RR,     2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h5};
        vecs[4]  = '{MODE_RR,     2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h5};
        vecs[5]  = '{MODE_RR,     2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h5};
        vecs[6]  = '{MODE_RR,     2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h7};
        vecs[7]  = '{MODE_RR,     2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0};
        vecs[8]  = '{MODE_MANUAL, 2'd1, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0};
        vecs[9]  = '{MODE_RR,     2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hA};
        vecs[10] = '{MODE_MANUAL, 2'd0, 4'b1000, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0};
        vecs[11] = '{MODE_RR,     2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hC};
        vecs[12] = '{MODE_RR,     2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h7};

        do_reset();
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_data",  32'(bus.out_data),  32'd0);
        check("reset out_chan",  32'(bus.out_chan),  32'd0);
        #1;
        check("reset in_ready",  32'(bus.in_ready),  32'd0);

        bus.in_data = 16'hCA75;
        bus.in_last = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            bus.mode      = vecs[i].mode;
            bus.select    = vecs[i].sel;
            bus.in_valid  = vecs[i].valid;
            bus.out_ready = vecs[i].rdy;
            cycle_check($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                        vecs[i].exp_chan, vecs[i].exp_data);
        end

        // Lone requester streams back-to-back, then round-robin moves past it.
        bus.mode      = MODE_RR;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            cycle_check($sformatf("solo%0d", i), 4'b1000, 1'b1, 2'd3, 4'hC);
        end
        bus.in_valid = 4'b1010;
        cycle_check("solo_then_ch1", 4'b0010, 1'b1, 2'd1, 4'h7);

        // Asynchronous reset while a beat is held.
        bus.in_valid = 4'b1111;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst out_data",  32'(bus.out_data),  32'd0);
        check("async_rst out_chan",  32'(bus.out_chan),  32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle_check("post_rst first", 4'b0001, 1'b1, 2'd0, 4'h5);

`ifdef MUX_PKT_LOCK_EN
        do_reset();
        bus.in_data   = 16'hCA75;
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0111;
        bus.in_last   = 4'b1101;
        bus.mode      = MODE_MANUAL;
        bus.select    = 2'd1;
        cycle_check("lock beat0", 4'b0010, 1'b1, 2'd1, 4'h7);
        bus.mode      = MODE_RR;
        bus.select    = 2'd0;
        cycle_check("lock beat1", 4'b0010, 1'b1, 2'd1, 4'h7);
        bus.in_last   = 4'b1111;
        cycle_check("lock beat2", 4'b0010, 1'b1, 2'd1, 4'h7);
        cycle_check("lock release", 4'b0100, 1'b1, 2'd2, 4'hA);
`endif

        do_reset();
        for (int n = 0; n < 400; n++) begin
            random_cycle(n);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, BITS-wide stream multiplexer with a valid/ready handshake on every input and on the output.
- Two modes: manual select, which behaves like the existing combinational 4x1 mux but is registered and handshaked, and round-robin arbitration across all requesting channels.
- One registered output stage.
- Sits between multiple producers and a single downstream consumer.

Parameters:
- BITS, 4, data width per channel
- CHANNELS, 4, number of input channels (>= 2; need not be a power of 2)
- SEL_W, $clog2(CHANNELS), derived localparam (not overridable); width of select and channel index

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = MODE_MANUAL, 1 = MODE_RR (type mux_mode_e)
- select  in  SEL_W  channel index used in MODE_MANUAL
- in_data  in  CHANNELS*BITS  packed channel data; channel i at [i*BITS +: BITS]
- in_valid  in  CHANNELS  per-channel valid
- in_last  in  CHANNELS  per-channel end-of-packet marker (used only with MUX_PKT_LOCK_EN)
- in_ready  out  CHANNELS  per-channel ready
- out_data  out  BITS  registered output data
- out_chan  out  SEL_W  index of the channel that sourced out_data
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready

Behaviour:
- Interface: clk; reset_n is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1 (so channel 0 wins the first RR arbitration), lock=0.
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat only when load=1.
- Grant, MODE_MANUAL: grant=select if in_valid[select]. If select >= CHANNELS, there is no grant.
- Grant, MODE_RR: first valid channel found searching last_grant+1, last_grant+2, ..., wrapping modulo CHANNELS.
- in_ready[i] = load && grant_valid && grant==i. This is combinational from in_valid, mode, select and out_ready. At most one in_ready bit is high.
- Transfer on input i: in_valid[i] && in_ready[i]. Next edge: out_data<=in data of channel i, out_chan<=i, out_valid<=1, last_grant<=i.
- Output side: if load && no grant, out_valid<=0 at the next edge. If out_valid && !out_ready, out_data and out_chan hold stable and all in_ready bits are 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput is 1 beat/cycle when out_ready is held at 1.
- last_grant updates only on a transfer. In MODE_MANUAL it also updates, so RR resumes after the last manually chosen channel.
- Mode or select change: takes effect at the next arbitration; the beat held in the output register is never altered.
- Single requester in MODE_RR: that channel wins every cycle with no idle bubbles.
- Reset asserted mid-stream: the output register is cleared immediately and the pending beat is dropped. Upstream must treat it as not transferred.

Optional Feature:
- Macro: MUX_PKT_LOCK_EN.
- Defined: after a transfer with in_last[i]=0, lock<=1 and the grant is forced to channel i, ignoring mode, select and other requesters. lock clears on the transfer with in_last[i]=1. If the locked channel drops valid, nothing is granted; the lock still holds.
- Undefined: in_last is ignored and there is no lock register; every beat is arbitrated independently.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {MODE_MANUAL, MODE_RR} mux_mode_e
  - function clog2_min1 (SEL_W >= 1)
- Sub-module rr_arbiter #(N):
  - purely combinational
  - inputs: req[N], last_grant
  - outputs: grant_valid, grant index
  - used by stream_mux_rr for MODE_RR; the manual path stays in the top module.

Test Plan:
- MODE_MANUAL, select=2, in_valid=4'b1111, ch2 data=4'hA, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A, out_chan=2, out_valid=1.
- MODE_RR, all 4 valid every cycle, out_ready=1 -> out_chan sequence 0,1,2,3,0,1; one beat per cycle.
- MODE_RR, out_valid=1 and out_ready=0 for 3 cycles -> out_data and out_chan stable, in_ready=0; on out_ready=1, the next channel in RR order transfers.
- MODE_RR, only ch3 valid for 5 cycles -> five consecutive transfers from ch3 with no gaps; then ch1 and ch3 valid -> ch1 wins next.
- reset_n pulsed low mid-stream with out_valid=1 -> out_valid=0 and out_data=0 immediately; after release, first RR grant goes to channel 0.
- MUX_PKT_LOCK_EN defined, ch1 sends beats with in_last=0,0,1 while ch0 and ch2 are valid -> three consecutive ch1 beats, then ch2 is granted next.
